// File: rtl/ace_arb_pkg.sv
// Shared types for the ACE request arbiter: FSM state and request type encodings.
`default_nettype none

package ace_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10,
    DONE      = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_READ       = 2'b00,
    REQ_WRITEBACK  = 2'b01,
    REQ_INVALIDATE = 2'b10,
    REQ_RESERVED   = 2'b11
  } req_type_t;

endpackage : ace_arb_pkg

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping.
`default_nettype none

module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic [PTR_W:0] cand;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      if (elig_i[cand[PTR_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[PTR_W-1:0];
      end
    end
  end

endmodule : rr_priority_picker

`default_nettype wire

// File: rtl/ace_req_arbiter.sv
// Round-robin arbiter sharing one ACE master port between NUM_REQ cache controllers.
`default_nettype none

module ace_req_arbiter
  import ace_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_type,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          bus_valid,
  output logic [1:0]                    bus_type,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [ID_WIDTH-1:0]           bus_id,
  input  logic                          bus_accept,
  input  logic                          bus_done,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic [1:0]             type_q, type_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NUM_REQ-1:0]     mask_q;
  logic                   busy_q;

  logic [NUM_REQ-1:0]     elig;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     grant_onehot;

  assign grant_onehot = NUM_REQ'(1) << grant_q;
  assign req_done     = (state_q == DONE) ? grant_onehot : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = req_valid[i]
                   && (req_type[2*i +: 2] != REQ_RESERVED)
                   && !req_done[i]
                   && !mask_q[i];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    type_d  = type_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          type_d  = req_type[2*int'(pick_idx) +: 2];
          addr_d  = req_addr[ADDR_WIDTH*int'(pick_idx) +: ADDR_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A response without acceptance cannot belong to this transaction.
        if (bus_accept) begin
          state_d = bus_done ? DONE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      // Blocks a stale req_valid from the just-completed requester for one cycle.
      mask_q  <= req_done;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    bus_id              = '0;
    bus_id[PTR_W-1:0]   = grant_q;
  end

  assign bus_valid = (state_q == ISSUE);
  assign bus_type  = type_q;
  assign bus_addr  = addr_q;
  assign busy      = busy_q;

endmodule : ace_req_arbiter

`default_nettype wire

// File: tb/tb_ace_req_arbiter.sv
// Self-checking bench for ace_req_arbiter: vector table, directed corner sequences, random vs model.
`default_nettype none

module tb_ace_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int IW = 3;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [2*N-1:0]       req_type;
  logic [AW*N-1:0]      req_addr;
  logic [N-1:0]         req_done;
  logic                 bus_valid;
  logic [1:0]           bus_type;
  logic [AW-1:0]        bus_addr;
  logic [IW-1:0]        bus_id;
  logic                 bus_accept;
  logic                 bus_done;
  logic                 busy;

  ace_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_done   (req_done),
    .bus_valid  (bus_valid),
    .bus_type   (bus_type),
    .bus_addr   (bus_addr),
    .bus_id     (bus_id),
    .bus_accept (bus_accept),
    .bus_done   (bus_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the bus and how far its transaction has got.
  int           m_owner;
  bit           m_acc;
  bit           m_fin;
  int           m_ptr;
  int           m_mask;
  logic [1:0]   m_type;
  logic [AW-1:0] m_addr;

  task automatic model_reset();
    m_owner = -1; m_acc = 0; m_fin = 0; m_ptr = 0; m_mask = -1;
    m_type = '0; m_addr = '0;
  endtask

  task automatic model_check();
    logic [N-1:0] e_done;
    logic         e_bv;
    e_done = '0;
    if (m_fin) e_done[m_owner] = 1'b1;
    e_bv = (m_owner >= 0) && !m_acc && !m_fin;
    chk("model_busy", 64'(busy), 64'(m_owner >= 0));
    chk("model_bus_valid", 64'(bus_valid), 64'(e_bv));
    chk("model_req_done", 64'(req_done), 64'(e_done));
    if (e_bv) begin
      chk("model_bus_type", 64'(bus_type), 64'(m_type));
      chk("model_bus_addr", 64'(bus_addr), 64'(m_addr));
      chk("model_bus_id", 64'(bus_id), 64'(m_owner));
    end
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [2*N-1:0] t,
                            input logic [AW*N-1:0] a, input logic acc, input logic dn);
    int w;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && v[idx] && t[2*idx +: 2] != 2'b11 && idx != m_mask) w = idx;
      end
      m_mask = -1;
      if (w >= 0) begin
        m_owner = w; m_acc = 0; m_fin = 0;
        m_type = t[2*w +: 2];
        m_addr = a[AW*w +: AW];
      end
    end else if (m_fin) begin
      m_ptr = (m_owner + 1) % N;
      m_mask = m_owner;
      m_owner = -1; m_fin = 0; m_acc = 0;
    end else if (!m_acc) begin
      if (acc) begin
        if (dn) m_fin = 1; else m_acc = 1;
      end
    end else if (dn) begin
      m_fin = 1;
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [2*N-1:0] t,
                       input logic [AW*N-1:0] a, input logic acc, input logic dn);
    @(negedge clk);
    req_valid = v; req_type = t; req_addr = a; bus_accept = acc; bus_done = dn;
    model_check();
    model_step(v, t, a, acc, dn);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "_req_done"}, 64'(req_done), 64'd0);
    chk({tag, "_bus_type"}, 64'(bus_type), 64'd0);
    chk({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
    chk({tag, "_bus_id"}, 64'(bus_id), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0; req_type = '0; req_addr = '0; bus_accept = 0; bus_done = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]    vld;
    logic [2*N-1:0]  typ;
    logic [AW*N-1:0] addr;
    logic            acc;
    logic            dn;
    logic            e_bv;
    logic [1:0]      e_type;
    logic [AW-1:0]   e_addr;
    logic [IW-1:0]   e_id;
    logic [N-1:0]    e_done;
    logic            e_busy;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] vld, logic [2*N-1:0] typ, logic [AW*N-1:0] addr,
                              logic acc, logic dn, logic e_bv, logic [1:0] e_type,
                              logic [AW-1:0] e_addr, logic [IW-1:0] e_id,
                              logic [N-1:0] e_done, logic e_busy);
    vec_t r;
    r.vld = vld; r.typ = typ; r.addr = addr; r.acc = acc; r.dn = dn;
    r.e_bv = e_bv; r.e_type = e_type; r.e_addr = e_addr; r.e_id = e_id;
    r.e_done = e_done; r.e_busy = e_busy;
    return r;
  endfunction

  vec_t vecs[15];
  int   grants[$];
  int   n_dones;
  logic [AW*N-1:0] a40, a80;

  initial begin
    reset = 1'b0;
    req_valid = '0; req_type = '0; req_addr = '0; bus_accept = 0; bus_done = 0;
    model_reset();

    // Single read from requester 0, then reserved-type requester 0 vs writeback from 1.
    vecs[0]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 0, 0, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[1]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 0, 0, 1, 2'b00, 32'h1000, 3'd0, 2'b00, 1);
    vecs[2]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 1, 0, 1, 2'b00, 32'h1000, 3'd0, 2'b00, 1);
    vecs[3]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 0, 0, 0, 2'b00, 32'h0,    3'd0, 2'b00, 1);
    vecs[4]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 0, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 1);
    vecs[5]  = mk(2'b01, 4'b0000, {32'h0, 32'h1000}, 0, 0, 0, 2'b00, 32'h0,    3'd0, 2'b01, 1);
    vecs[6]  = mk(2'b00, 4'b0000, {32'h0, 32'h1000}, 0, 0, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[7]  = mk(2'b00, 4'b0000, {32'h0, 32'h1000}, 0, 0, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[8]  = mk(2'b11, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[9]  = mk(2'b11, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 1, 2'b01, 32'h2000, 3'd1, 2'b00, 1);
    vecs[10] = mk(2'b11, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b10, 1);
    vecs[11] = mk(2'b11, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[12] = mk(2'b01, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[13] = mk(2'b01, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);
    vecs[14] = mk(2'b01, 4'b0111, {32'h2000, 32'h3000}, 1, 1, 0, 2'b00, 32'h0,    3'd0, 2'b00, 0);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].vld, vecs[i].typ, vecs[i].addr, vecs[i].acc, vecs[i].dn);
      chk($sformatf("row%0d_bus_valid", i), 64'(bus_valid), 64'(vecs[i].e_bv));
      chk($sformatf("row%0d_req_done", i), 64'(req_done), 64'(vecs[i].e_done));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_bv) begin
        chk($sformatf("row%0d_bus_type", i), 64'(bus_type), 64'(vecs[i].e_type));
        chk($sformatf("row%0d_bus_addr", i), 64'(bus_addr), 64'(vecs[i].e_addr));
        chk($sformatf("row%0d_bus_id", i), 64'(bus_id), 64'(vecs[i].e_id));
      end
    end

    // Both requesters continuously valid with immediate accept+done: grants alternate.
    do_reset();
    grants.delete();
    n_dones = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(2'b11, 4'b0000, {32'hB0, 32'hA0}, 1, 1);
      if (bus_valid) grants.push_back(int'(bus_id));
      if (req_done != '0) n_dones++;
    end
    chk("alt_grant_count", 64'(grants.size()), 64'd4);
    chk("alt_done_count", 64'(n_dones), 64'd4);
    if (grants.size() == 4) begin
      chk("alt_g0", 64'(grants[0]), 64'd0);
      chk("alt_g1", 64'(grants[1]), 64'd1);
      chk("alt_g2", 64'(grants[2]), 64'd0);
      chk("alt_g3", 64'(grants[3]), 64'd1);
    end
    repeat (4) cycle(2'b00, 4'b0000, '0, 1, 1);

    // Address change during WAIT_RESP must not reach the bus.
    do_reset();
    a40 = {32'h40, 32'h0};
    a80 = {32'h80, 32'h0};
    cycle(2'b10, 4'b0000, a40, 0, 0);
    cycle(2'b10, 4'b0000, a40, 1, 0);
    chk("frz_issue_addr", 64'(bus_addr), 64'h40);
    cycle(2'b10, 4'b0000, a80, 0, 0);
    chk("frz_wait_addr", 64'(bus_addr), 64'h40);
    cycle(2'b00, 4'b0000, a80, 0, 1);
    chk("frz_wait2_addr", 64'(bus_addr), 64'h40);
    cycle(2'b00, 4'b0000, a80, 0, 0);
    chk("frz_done_addr", 64'(bus_addr), 64'h40);
    chk("frz_done_pulse", 64'(req_done), 64'b10);
    cycle(2'b00, 4'b0000, a80, 0, 0);

    // Lone bus_done in ISSUE is ignored; accept+done together goes straight to DONE.
    do_reset();
    cycle(2'b01, 4'b0000, {32'h0, 32'h55}, 0, 0);
    cycle(2'b01, 4'b0000, {32'h0, 32'h55}, 0, 1);
    chk("lone_done_issue", 64'(bus_valid), 64'd1);
    cycle(2'b00, 4'b0000, {32'h0, 32'h55}, 1, 1);
    chk("lone_done_still_issue", 64'(bus_valid), 64'd1);
    cycle(2'b00, 4'b0000, '0, 0, 0);
    chk("acc_done_same_cycle", 64'(req_done), 64'b01);
    cycle(2'b00, 4'b0000, '0, 0, 0);

    // Reset while in WAIT_RESP of requester 1 (pointer at 1), then pointer must be 0.
    do_reset();
    cycle(2'b01, 4'b0000, {32'h20, 32'h10}, 0, 0);
    cycle(2'b00, 4'b0000, {32'h20, 32'h10}, 1, 1);
    cycle(2'b00, 4'b0000, {32'h20, 32'h10}, 0, 0);
    cycle(2'b11, 4'b0000, {32'h20, 32'h10}, 0, 0);
    cycle(2'b00, 4'b0101, {32'h20, 32'h10}, 1, 0);
    chk("pre_rst_id", 64'(bus_id), 64'd1);
    cycle(2'b00, 4'b0000, {32'h20, 32'h10}, 0, 0);
    chk("pre_rst_wait_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    bus_done = 1'b1;
    @(negedge clk);
    chk("rst_no_done", 64'(req_done), 64'd0);
    bus_done = 1'b0;
    reset = 1'b1;
    cycle(2'b11, 4'b0000, {32'h20, 32'h10}, 0, 0);
    cycle(2'b11, 4'b0000, {32'h20, 32'h10}, 1, 1);
    chk("post_rst_ptr_zero", 64'(bus_id), 64'd0);
    cycle(2'b00, 4'b0000, '0, 0, 0);
    cycle(2'b00, 4'b0000, '0, 0, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0]    rv;
      logic [2*N-1:0]  rt;
      logic [AW*N-1:0] ra;
      rv = N'($urandom_range(0, (1 << N) - 1));
      rt = (2*N)'($urandom);
      ra = {$urandom, $urandom};
      cycle(rv, rt, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_ace_req_arbiter

`default_nettype wire
